fofb_cc_timeframe_ctrl: RTL and testbench
=========================================

// Module: fofb_cc_timeframe_ctrl
// PURPOSE
//  Sequences the FOFB communication controller: holds the GTP in reset after power-up,
//  then generates timeframe_start / timeframe_end for the CC datapath with runtime-programmable
//  period and end offset. Sits beside fofb_cc_top in the user-clock domain and replaces the
//  free-running pulse generators used so far.
// PARAMETERS
//  STARTUP_CYCLES  10000  cycles gtp_reset_o held high after reset release
//  PERIOD_DEF      10072  reset-value frame period, cycles start-to-start
//  END_OFF_DEF     7500   reset-value offset, cycles from start rise to end rise
//  CNT_W           16     width of period/offset counters and config ports
// PORTS
//  userclk_i         in   1      CC user clock; all logic on rising edge
//  mgtreset_i        in   1      asynchronous, active-high reset
//  enable_i          in   1      level; run timeframes when high
//  cfg_period_i      in   CNT_W  new period, sampled on cfg_load_i
//  cfg_end_off_i     in   CNT_W  new end offset, sampled on cfg_load_i
//  cfg_load_i        in   1      one-cycle strobe: request config update
//  ext_sync_i        in   1      external frame sync (async); used only with macro
//  gtp_reset_o       out  1      GTP/MGT reset to CC core
//  timeframe_start_o out  1      one-cycle pulse at frame start
//  timeframe_end_o   out  1      level: high from end point until next start pulse
//  frame_count_o     out  32     start pulses issued since reset
//  cfg_err_o         out  1      sticky: last cfg_load_i rejected
//  state_o           out  2      current FSM state (debug)
// BEHAVIOUR
//  - Reset: gtp_reset_o=1, all other outputs 0, state HOLD, active cfg = PERIOD_DEF/END_OFF_DEF.
//    Reset mid-frame aborts immediately; no partial pulses after release.
//  - FSM: HOLD -> (STARTUP_CYCLES elapsed) WAIT, gtp_reset_o falls on that edge;
//    WAIT -> (enable_i=1) RUN; RUN -> (enable_i=0 at frame boundary) WAIT.
//  - Entering RUN: timeframe_start_o pulses on the first edge enable_i is seen high in WAIT.
//  - RUN: start pulses exactly PERIOD cycles apart; timeframe_end_o rises exactly END_OFF
//    cycles after a start rise; falls on the same edge the next start rises.
//  - enable_i low in RUN: current frame completes; at boundary no start pulse,
//    timeframe_end_o cleared, go to WAIT. enable_i ignored in HOLD.
//  - All outputs registered; counter reload and start pulse on same edge, no bubble.
//  - frame_count_o +1 per start pulse; wraps 2^32-1 -> 0.
//  - Config valid iff period >= 2 and 1 <= end_off <= period-1. Invalid load: cfg_err_o=1,
//    active config untouched. Valid load: cfg_err_o=0 next cycle.
//  - Valid load in RUN goes to shadow; applied at next frame boundary (last shadow wins if
//    several loads in one frame). Valid load in HOLD/WAIT applies next cycle.
//  - cfg_load_i on the boundary edge itself: shadow taken at the following boundary.
// CONFIGURATION
//  FOFB_CC_TIMEFRAME_EXT_SYNC_EN defined: ext_sync_i double-flop synchronised; a rising edge
//  in RUN forces a start pulse 3 cycles after the ext edge (2 sync + 1 reg), restarting the
//  counter and clearing timeframe_end_o; pending shadow config applies there. Edge in
//  HOLD/WAIT ignored. Edge coincident with natural boundary: a single start pulse only.
//  Undefined: ext_sync_i ignored, no synchroniser flops; port stays for a fixed footprint.
// STRUCTURE
//  fofb_cc_timeframe_pkg: state enum {HOLD,WAIT,RUN} 2-bit encoding, CNT_W default,
//  config-valid check function. Sub-module fofb_cc_sync_edge (2-flop sync + rise detect),
//  instantiated only under the macro. Counter/FSM/shadow regs stay in this module.
// TESTING
//  1 reset 1 cycle, enable_i=1 -> gtp_reset_o low after 10000 cycles; first start next edge.
//  2 defaults -> start pulses 10072 apart; end rises 7500 after each start; frame_count 1,2,3.
//  3 cfg 100/40 loaded mid-frame -> current frame keeps 10072; next frames 100 apart, end +40.
//  4 cfg 50/50 and 1/0 -> cfg_err_o=1, timing unchanged; then 64/10 -> cfg_err_o=0.
//  5 enable_i low mid-frame -> frame completes, no further start, end low, state_o=WAIT.
//  6 macro on: ext_sync_i rise at frame midpoint -> start 3 cycles later, count resumes from it.

Source files
------------

// File: rtl/fofb_cc_timeframe_pkg.sv
// Shared types and helpers for the FOFB CC timeframe controller.
// Optional feature macro: FOFB_CC_TIMEFRAME_EXT_SYNC_EN (see top module).
package fofb_cc_timeframe_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } tf_state_t;

    function automatic logic cfg_valid(
        input logic [31:0] period,
        input logic [31:0] end_off
    );
        return (period >= 32'd2) && (end_off >= 32'd1) &&
               (end_off <= period - 32'd1);
    endfunction

endpackage

// File: rtl/fofb_cc_sync_edge.sv
// Two-flop synchroniser with rising-edge detect for an asynchronous input.
// Used by the timeframe controller only with FOFB_CC_TIMEFRAME_EXT_SYNC_EN.
module fofb_cc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic [2:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= 3'b000;
        end else begin
            sr <= {sr[1:0], din};
        end
    end

    assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/fofb_cc_timeframe_ctrl.sv
// GTP reset sequencing and programmable timeframe start/end generation.
// Define FOFB_CC_TIMEFRAME_EXT_SYNC_EN to let ext_sync_i restart frames.
module fofb_cc_timeframe_ctrl
    import fofb_cc_timeframe_pkg::*;
#(
    parameter int STARTUP_CYCLES = 10000,
    parameter int PERIOD_DEF     = 10072,
    parameter int END_OFF_DEF    = 7500,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             userclk_i,
    input  logic             mgtreset_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [CNT_W-1:0] cfg_end_off_i,
    input  logic             cfg_load_i,
    input  logic             ext_sync_i,
    output logic             gtp_reset_o,
    output logic             timeframe_start_o,
    output logic             timeframe_end_o,
    output logic [31:0]      frame_count_o,
    output logic             cfg_err_o,
    output logic [1:0]       state_o
);

    localparam int HOLD_W = $clog2(STARTUP_CYCLES + 1);

    tf_state_t         state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  end_off;
    logic [CNT_W-1:0]  sh_period;
    logic [CNT_W-1:0]  sh_end_off;
    logic              sh_pend;
    logic              cfg_ok;
    logic              load_ok;
    logic              load_bad;
    logic              ext_rise;
    logic              bnd;

`ifdef FOFB_CC_TIMEFRAME_EXT_SYNC_EN
    fofb_cc_sync_edge u_sync (
        .clk  (userclk_i),
        .rst  (mgtreset_i),
        .din  (ext_sync_i),
        .rise (ext_rise)
    );
`else
    logic unused_ext_sync;
    assign unused_ext_sync = ext_sync_i;
    assign ext_rise        = 1'b0;
`endif

    assign cfg_ok   = cfg_valid(32'(cfg_period_i), 32'(cfg_end_off_i));
    assign load_ok  = cfg_load_i & cfg_ok;
    assign load_bad = cfg_load_i & ~cfg_ok;

    // An external sync edge ends the frame early, exactly like a natural boundary
    assign bnd = (state == RUN) && ((cnt == period) || ext_rise);

    assign state_o = state;

    always_ff @(posedge userclk_i or posedge mgtreset_i) begin
        if (mgtreset_i) begin
            state             <= HOLD;
            hold_cnt          <= '0;
            cnt               <= '0;
            period            <= CNT_W'(PERIOD_DEF);
            end_off           <= CNT_W'(END_OFF_DEF);
            sh_period         <= CNT_W'(PERIOD_DEF);
            sh_end_off        <= CNT_W'(END_OFF_DEF);
            sh_pend           <= 1'b0;
            gtp_reset_o       <= 1'b1;
            timeframe_start_o <= 1'b0;
            timeframe_end_o   <= 1'b0;
            frame_count_o     <= '0;
            cfg_err_o         <= 1'b0;
        end else begin
            timeframe_start_o <= 1'b0;

            if (load_bad) begin
                cfg_err_o <= 1'b1;
            end else if (load_ok) begin
                cfg_err_o <= 1'b0;
            end

            unique case (state)
                HOLD: begin
                    if (load_ok) begin
                        period  <= cfg_period_i;
                        end_off <= cfg_end_off_i;
                    end
                    if (hold_cnt == HOLD_W'(STARTUP_CYCLES - 1)) begin
                        state       <= WAIT;
                        gtp_reset_o <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (enable_i) begin
                        state             <= RUN;
                        timeframe_start_o <= 1'b1;
                        cnt               <= CNT_W'(1);
                        frame_count_o     <= frame_count_o + 32'd1;
                        sh_pend           <= 1'b0;
                        if (sh_pend) begin
                            period  <= sh_period;
                            end_off <= sh_end_off;
                        end
                    end
                    if (load_ok) begin
                        period  <= cfg_period_i;
                        end_off <= cfg_end_off_i;
                    end
                end
                RUN: begin
                    if (bnd) begin
                        timeframe_end_o <= 1'b0;
                        cnt             <= CNT_W'(1);
                        if (sh_pend) begin
                            period  <= sh_period;
                            end_off <= sh_end_off;
                            sh_pend <= 1'b0;
                        end
                        if (enable_i || ext_rise) begin
                            timeframe_start_o <= 1'b1;
                            frame_count_o     <= frame_count_o + 32'd1;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == end_off) begin
                            timeframe_end_o <= 1'b1;
                        end
                    end
                    // Loads on the boundary edge land here and wait a full frame
                    if (load_ok) begin
                        sh_period  <= cfg_period_i;
                        sh_end_off <= cfg_end_off_i;
                        sh_pend    <= 1'b1;
                    end
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fofb_cc_timeframe_ctrl.sv
// Directed self-checking bench for fofb_cc_timeframe_ctrl.
// The ext-sync scenario runs only when FOFB_CC_TIMEFRAME_EXT_SYNC_EN is defined.
module tb_fofb_cc_timeframe_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] cfg_period;
    logic [15:0] cfg_end_off;
    logic        cfg_load;
    logic        ext_sync;
    logic        gtp_reset;
    logic        tf_start;
    logic        tf_end;
    logic [31:0] frame_count;
    logic        cfg_err;
    logic [1:0]  state;

    int tests;
    int fails;
    int exp_cnt;

    fofb_cc_timeframe_ctrl dut (
        .userclk_i         (clk),
        .mgtreset_i        (rst),
        .enable_i          (enable),
        .cfg_period_i      (cfg_period),
        .cfg_end_off_i     (cfg_end_off),
        .cfg_load_i        (cfg_load),
        .ext_sync_i        (ext_sync),
        .gtp_reset_o       (gtp_reset),
        .timeframe_start_o (tf_start),
        .timeframe_end_o   (tf_end),
        .frame_count_o     (frame_count),
        .cfg_err_o         (cfg_err),
        .state_o           (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({gtp_reset, tf_start, tf_end, cfg_err} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=1000",
                     {gtp_reset, tf_start, tf_end, cfg_err});
        end
        tests++;
        if (frame_count !== 32'd0 || state !== 2'd0) begin
            fails++;
            $display("FAIL reset_state got cnt=%0d st=%0d exp 0 0",
                     frame_count, state);
        end
        rst = 1'b0;
    endtask

    task automatic test_startup();
        repeat (9999) @(negedge clk);
        tests++;
        if (gtp_reset !== 1'b1 || state !== 2'd0) begin
            fails++;
            $display("FAIL startup_hold got gtp=%b st=%0d exp 1 0",
                     gtp_reset, state);
        end
        @(negedge clk);
        tests++;
        if (gtp_reset !== 1'b0 || state !== 2'd1 || tf_start !== 1'b0) begin
            fails++;
            $display("FAIL startup_release got gtp=%b st=%0d s=%b exp 0 1 0",
                     gtp_reset, state, tf_start);
        end
        @(negedge clk);
        exp_cnt = 1;
        tests++;
        if (tf_start !== 1'b1 || state !== 2'd2 || frame_count !== 32'd1) begin
            fails++;
            $display("FAIL first_start got s=%b st=%0d cnt=%0d exp 1 2 1",
                     tf_start, state, frame_count);
        end
    endtask

    task automatic test_defaults();
        logic es, ee;
        for (int f = 0; f < 2; f++) begin
            for (int k = 1; k <= 10072; k++) begin
                @(negedge clk);
                if (k == 7499 || k == 7500 || k == 10071 || k == 10072) begin
                    es = (k == 10072);
                    ee = (k >= 7500 && k < 10072);
                    tests++;
                    if (tf_start !== es || tf_end !== ee) begin
                        fails++;
                        $display("FAIL default_frame k=%0d got s=%b e=%b exp %b %b",
                                 k, tf_start, tf_end, es, ee);
                    end
                end
            end
            exp_cnt++;
            tests++;
            if (frame_count !== 32'(exp_cnt)) begin
                fails++;
                $display("FAIL default_count got=%0d exp=%0d",
                         frame_count, exp_cnt);
            end
        end
    endtask

    task automatic test_cfg_midframe();
        logic es, ee;
        int p, e;
        for (int f = 0; f < 3; f++) begin
            p = (f == 0) ? 10072 : 100;
            e = (f == 0) ? 7500 : 40;
            for (int k = 1; k <= p; k++) begin
                cfg_load = (f == 0 && k == 101);
                cfg_period = 16'd100;
                cfg_end_off = 16'd40;
                @(negedge clk);
                if (k == e - 1 || k == e || k == p - 1 || k == p) begin
                    es = (k == p);
                    ee = (k >= e && k < p);
                    tests++;
                    if (tf_start !== es || tf_end !== ee) begin
                        fails++;
                        $display("FAIL cfg_mid f=%0d k=%0d got s=%b e=%b exp %b %b",
                                 f, k, tf_start, tf_end, es, ee);
                    end
                end
            end
            cfg_load = 1'b0;
            exp_cnt++;
            tests++;
            if (frame_count !== 32'(exp_cnt)) begin
                fails++;
                $display("FAIL cfg_mid_count got=%0d exp=%0d",
                         frame_count, exp_cnt);
            end
        end
    endtask

    task automatic test_cfg_invalid();
        logic es, ee;
        int p, e;
        for (int f = 0; f < 3; f++) begin
            p = (f == 2) ? 64 : 100;
            e = (f == 2) ? 10 : 40;
            for (int k = 1; k <= p; k++) begin
                cfg_load = 1'b0;
                if (f == 0 && k == 6) begin
                    cfg_load = 1'b1;
                    cfg_period = 16'd50;
                    cfg_end_off = 16'd50;
                end
                if (f == 0 && k == 11) begin
                    cfg_load = 1'b1;
                    cfg_period = 16'd1;
                    cfg_end_off = 16'd0;
                end
                if (f == 1 && k == 21) begin
                    cfg_load = 1'b1;
                    cfg_period = 16'd64;
                    cfg_end_off = 16'd10;
                end
                @(negedge clk);
                if ((f == 0 && (k == 6 || k == 11)) || (f == 1 && k == 21)) begin
                    ee = (f == 0);
                    tests++;
                    if (cfg_err !== ee) begin
                        fails++;
                        $display("FAIL cfg_err f=%0d k=%0d got=%b exp=%b",
                                 f, k, cfg_err, ee);
                    end
                end
                if (k == e - 1 || k == e || k == p - 1 || k == p) begin
                    es = (k == p);
                    ee = (k >= e && k < p);
                    tests++;
                    if (tf_start !== es || tf_end !== ee) begin
                        fails++;
                        $display("FAIL cfg_inv f=%0d k=%0d got s=%b e=%b exp %b %b",
                                 f, k, tf_start, tf_end, es, ee);
                    end
                end
            end
            cfg_load = 1'b0;
            exp_cnt++;
        end
        tests++;
        if (frame_count !== 32'(exp_cnt)) begin
            fails++;
            $display("FAIL cfg_inv_count got=%0d exp=%0d", frame_count, exp_cnt);
        end
    endtask

    task automatic test_disable();
        logic ee;
        for (int k = 1; k <= 64; k++) begin
            if (k == 21) enable = 1'b0;
            @(negedge clk);
            if (k == 9 || k == 10 || k == 63 || k == 64) begin
                ee = (k >= 10 && k < 64);
                tests++;
                if (tf_start !== 1'b0 || tf_end !== ee) begin
                    fails++;
                    $display("FAIL disable k=%0d got s=%b e=%b exp 0 %b",
                             k, tf_start, tf_end, ee);
                end
            end
        end
        repeat (3) @(negedge clk);
        tests++;
        if (state !== 2'd1 || tf_start !== 1'b0 || frame_count !== 32'(exp_cnt)) begin
            fails++;
            $display("FAIL disable_wait got st=%0d s=%b cnt=%0d exp 1 0 %0d",
                     state, tf_start, frame_count, exp_cnt);
        end
    endtask

    task automatic test_wait_load();
        logic es, ee;
        cfg_load = 1'b1;
        cfg_period = 16'd20;
        cfg_end_off = 16'd5;
        @(negedge clk);
        cfg_load = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        exp_cnt++;
        tests++;
        if (tf_start !== 1'b1 || state !== 2'd2 || frame_count !== 32'(exp_cnt)) begin
            fails++;
            $display("FAIL reenable got s=%b st=%0d cnt=%0d exp 1 2 %0d",
                     tf_start, state, frame_count, exp_cnt);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 4 || k == 5 || k == 19 || k == 20) begin
                es = (k == 20);
                ee = (k >= 5 && k < 20);
                tests++;
                if (tf_start !== es || tf_end !== ee) begin
                    fails++;
                    $display("FAIL wait_load k=%0d got s=%b e=%b exp %b %b",
                             k, tf_start, tf_end, es, ee);
                end
            end
        end
        exp_cnt++;
    endtask

    task automatic test_boundary_load();
        logic es, ee;
        int p, e;
        for (int f = 0; f < 3; f++) begin
            p = (f == 2) ? 32 : 20;
            e = (f == 2) ? 8 : 5;
            for (int k = 1; k <= p; k++) begin
                cfg_load = (f == 0 && k == 20);
                cfg_period = 16'd32;
                cfg_end_off = 16'd8;
                @(negedge clk);
                if (k == e - 1 || k == e || k == p - 1 || k == p) begin
                    es = (k == p);
                    ee = (k >= e && k < p);
                    tests++;
                    if (tf_start !== es || tf_end !== ee) begin
                        fails++;
                        $display("FAIL bnd_load f=%0d k=%0d got s=%b e=%b exp %b %b",
                                 f, k, tf_start, tf_end, es, ee);
                    end
                end
            end
            cfg_load = 1'b0;
            exp_cnt++;
        end
        tests++;
        if (frame_count !== 32'(exp_cnt)) begin
            fails++;
            $display("FAIL bnd_load_count got=%0d exp=%0d", frame_count, exp_cnt);
        end
    endtask

`ifdef FOFB_CC_TIMEFRAME_EXT_SYNC_EN
    task automatic test_ext_sync();
        logic es, ee;
        for (int k = 1; k <= 14; k++) begin
            if (k == 12) ext_sync = 1'b1;
            @(negedge clk);
            if (k == 13 || k == 14) begin
                es = (k == 14);
                ee = (k == 13);
                tests++;
                if (tf_start !== es || tf_end !== ee) begin
                    fails++;
                    $display("FAIL ext_sync k=%0d got s=%b e=%b exp %b %b",
                             k, tf_start, tf_end, es, ee);
                end
            end
        end
        exp_cnt++;
        tests++;
        if (frame_count !== 32'(exp_cnt)) begin
            fails++;
            $display("FAIL ext_sync_count got=%0d exp=%0d", frame_count, exp_cnt);
        end
        ext_sync = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (k == 31 || k == 32) begin
                es = (k == 32);
                tests++;
                if (tf_start !== es) begin
                    fails++;
                    $display("FAIL ext_resume k=%0d got=%b exp=%b", k, tf_start, es);
                end
            end
        end
        exp_cnt++;
    endtask
`endif

    task automatic test_reset_midframe();
        repeat (10) @(negedge clk);
        tests++;
        if (tf_end !== 1'b1) begin
            fails++;
            $display("FAIL pre_abort_end got=%b exp=1", tf_end);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({gtp_reset, tf_start, tf_end, cfg_err} !== 4'b1000 ||
            frame_count !== 32'd0 || state !== 2'd0) begin
            fails++;
            $display("FAIL abort got flags=%b cnt=%0d st=%0d exp 1000 0 0",
                     {gtp_reset, tf_start, tf_end, cfg_err}, frame_count, state);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        tests++;
        if (tf_start !== 1'b0 || tf_end !== 1'b0 || state !== 2'd0 ||
            gtp_reset !== 1'b1) begin
            fails++;
            $display("FAIL post_abort got s=%b e=%b st=%0d gtp=%b exp 0 0 0 1",
                     tf_start, tf_end, state, gtp_reset);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_cnt = 0;
        rst = 1'b1;
        enable = 1'b1;
        cfg_period = 16'd0;
        cfg_end_off = 16'd0;
        cfg_load = 1'b0;
        ext_sync = 1'b0;
        test_reset();
        test_startup();
        test_defaults();
        test_cfg_midframe();
        test_cfg_invalid();
        test_disable();
        test_wait_load();
        test_boundary_load();
`ifdef FOFB_CC_TIMEFRAME_EXT_SYNC_EN
        test_ext_sync();
`endif
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
